// File: rtl/user_int_scheduler_pkg.sv
// Shared types and helpers for the user interrupt scheduler and the
// round-robin picker reused by the DMA channel schedulers.
package user_int_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    WR_WAIT  = 3'd2,
    ACK      = 3'd3,
    WAIT_INT = 3'd4,
    MSI      = 3'd5
  } sched_state_t;

  localparam int STATUS_QWORD_W = 64;

  // Arbitration is sized for the largest supported source count; callers
  // zero-pad their request vector up to RR_MAX_N.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping at n. ptr must be below n,
  // so a single conditional subtract replaces the modulo.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t   res;
    logic [5:0] cand;
    res = '0;
    for (int off = 0; off < RR_MAX_N; off++) begin
      if (off < n && !res.found) begin
        cand = {1'b0, ptr} + 6'(off);
        if (cand >= 6'(n)) cand = cand - 6'(n);
        if (req[cand[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/user_int_scheduler_rr_arbiter.sv
// Combinational N-input round-robin picker: grants the first requester at
// or after the pointer, cyclically.
module rr_arbiter
  import user_int_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [N-1:0]        i_req,
  input  logic [RR_IDX_W-1:0] i_rr_ptr,
  output logic [RR_IDX_W-1:0] o_grant_idx,
  output logic                o_grant_found
);

  logic [RR_MAX_N-1:0] w_req_ext;
  rr_pick_t            w_pick;

  // Widen the request vector to the picker's fixed width.
  genvar gi;
  generate
    for (gi = 0; gi < RR_MAX_N; gi++) begin : g_ext
      if (gi < N) begin : g_in
        assign w_req_ext[gi] = i_req[gi];
      end else begin : g_pad
        assign w_req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_pick        = rr_pick(w_req_ext, i_rr_ptr, N);
  assign o_grant_idx   = w_pick.idx;
  assign o_grant_found = w_pick.found;

endmodule

// File: rtl/user_int_scheduler.sv
// Round-robin scheduler sharing one status-write channel and one MSI port
// among NUM_OF_INTERRUPTS user interrupt sources. Per grant: write the
// status qword to the host, ack the source, wait for its int_req, send MSI.
// Optional watchdog: define USER_INT_TIMEOUT_EN to bound the waiting states
// by TIMEOUT_CYCLES and raise a sticky timeout_err on expiry.
module user_int_scheduler
  import user_int_pkg::*;
#(
  parameter int NUM_OF_INTERRUPTS = 1,
  parameter int MSI_VECTOR_BASE   = 0,
  parameter int MSI_VEC_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                                   s_axi_clk,
  input  logic                                   s_axi_rstn,
  input  logic [NUM_OF_INTERRUPTS-1:0]           status_req,
  output logic [NUM_OF_INTERRUPTS-1:0]           status_ack,
  input  logic [STATUS_QWORD_W*NUM_OF_INTERRUPTS-1:0] status_qword,
  input  logic [STATUS_QWORD_W*NUM_OF_INTERRUPTS-1:0] status_addr,
  input  logic [NUM_OF_INTERRUPTS-1:0]           int_req,
  output logic                                   wr_valid,
  input  logic                                   wr_ready,
  output logic [63:0]                            wr_addr,
  output logic [63:0]                            wr_data,
  input  logic                                   wr_done,
  output logic                                   msi_req,
  output logic [MSI_VEC_WIDTH-1:0]               msi_vector,
  input  logic                                   msi_ack,
  output logic                                   busy,
  output logic                                   timeout_err
);

  sched_state_t              r_state;
  sched_state_t              w_state_next;
  logic [RR_IDX_W-1:0]       r_grant;
  logic [RR_IDX_W-1:0]       r_rr_ptr;
  logic [RR_IDX_W-1:0]       w_rr_ptr_next;
  logic [63:0]               r_wr_addr;
  logic [63:0]               r_wr_data;
  logic [MSI_VEC_WIDTH-1:0]  r_msi_vector;
  logic [RR_IDX_W-1:0]       w_grant_idx;
  logic                      w_grant_found;
  logic [63:0]               w_sel_addr;
  logic [63:0]               w_sel_data;
  logic                      w_int_hit;
  logic                      w_advance;
  logic                      w_tmo_hit;
  logic                      w_tmo_skip;

  rr_arbiter #(
    .N (NUM_OF_INTERRUPTS)
  ) u_rr_arbiter (
    .i_req         (status_req),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_idx   (w_grant_idx),
    .o_grant_found (w_grant_found)
  );

  // Select the candidate source's address/qword and the granted int_req bit.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_int_hit  = 1'b0;
    for (int k = 0; k < NUM_OF_INTERRUPTS; k++) begin
      if (w_grant_idx == RR_IDX_W'(k)) begin
        w_sel_addr = status_addr[k*STATUS_QWORD_W +: STATUS_QWORD_W];
        w_sel_data = status_qword[k*STATUS_QWORD_W +: STATUS_QWORD_W];
      end
      if (r_grant == RR_IDX_W'(k)) w_int_hit = int_req[k];
    end
  end

  // Pointer moves just past the source that was served.
  assign w_rr_ptr_next = (r_grant == RR_IDX_W'(NUM_OF_INTERRUPTS - 1)) ?
                         '0 : r_grant + RR_IDX_W'(1);

  // Next-state logic; normal events always take priority over a watchdog expiry.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      IDLE:     if (w_grant_found) w_state_next = WR_REQ;
      WR_REQ:   if (wr_ready) w_state_next = wr_done ? ACK : WR_WAIT;
      WR_WAIT:  if (wr_done || w_tmo_hit) w_state_next = ACK;
      ACK: begin
        w_state_next = w_tmo_skip ? IDLE : WAIT_INT;
        w_advance    = w_tmo_skip;
      end
      WAIT_INT: begin
        if (w_int_hit) begin
          w_state_next = MSI;
        end else if (w_tmo_hit) begin
          w_state_next = IDLE;
          w_advance    = 1'b1;
        end
      end
      MSI: begin
        if (msi_ack || w_tmo_hit) begin
          w_state_next = IDLE;
          w_advance    = 1'b1;
        end
      end
      default:  w_state_next = IDLE;
    endcase
  end

  // State, grant capture and round-robin pointer.
  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_msi_vector <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_grant_found) begin
        r_grant      <= w_grant_idx;
        r_wr_addr    <= w_sel_addr;
        r_wr_data    <= w_sel_data;
        r_msi_vector <= MSI_VEC_WIDTH'(MSI_VECTOR_BASE + 32'(w_grant_idx));
      end
      if (w_advance) r_rr_ptr <= w_rr_ptr_next;
    end
  end

`ifdef USER_INT_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_tmo_err;
  logic        r_tmo_skip;
  logic        w_tmo_counting;
  logic        w_tmo_fire;

  assign w_tmo_counting = (r_state == WR_WAIT) || (r_state == WAIT_INT) ||
                          (r_state == MSI);
  assign w_tmo_hit      = w_tmo_counting &&
                          (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_tmo_fire     = w_tmo_hit &&
                          !((r_state == WR_WAIT  && wr_done)   ||
                            (r_state == WAIT_INT && w_int_hit) ||
                            (r_state == MSI      && msi_ack));
  assign w_tmo_skip     = r_tmo_skip;
  assign timeout_err    = r_tmo_err;

  // Watchdog: count cycles spent in a waiting state, restart on every state change.
  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      r_tmo_cnt  <= '0;
      r_tmo_err  <= 1'b0;
      r_tmo_skip <= 1'b0;
    end else begin
      if (w_state_next != r_state) r_tmo_cnt <= '0;
      else if (w_tmo_counting)     r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (w_tmo_fire) r_tmo_err <= 1'b1;
      // An expired write still acks the source, then skips the MSI leg.
      if (r_state == WR_WAIT && w_tmo_fire) r_tmo_skip <= 1'b1;
      else if (r_state == ACK)              r_tmo_skip <= 1'b0;
    end
  end
`else
  // Without the watchdog the FSM waits indefinitely; the limit is inert.
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
  assign w_tmo_skip   = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // One-cycle ack to the granted source while in ACK.
  always_comb begin
    status_ack = '0;
    for (int k = 0; k < NUM_OF_INTERRUPTS; k++) begin
      if (r_state == ACK && r_grant == RR_IDX_W'(k)) status_ack[k] = 1'b1;
    end
  end

  assign wr_valid   = (r_state == WR_REQ);
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign msi_req    = (r_state == MSI);
  assign msi_vector = r_msi_vector;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_user_int_scheduler.sv
// Directed bench for user_int_scheduler (N=4): a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_user_int_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     status_req;
  logic [N-1:0]     status_ack;
  logic [64*N-1:0]  status_qword;
  logic [64*N-1:0]  status_addr;
  logic [N-1:0]     int_req;
  logic             wr_valid, wr_ready, wr_done;
  logic [63:0]      wr_addr, wr_data;
  logic             msi_req, msi_ack, busy, timeout_err;
  logic [4:0]       msi_vector;

  // Responder controls: auto mode is a zero-wait write engine whose wr_done
  // arrives the cycle after acceptance.
  bit               auto_wr;
  logic             man_ready, man_done;
  logic             r_done_auto;
  logic [N-1:0]     r_int_auto;

  logic [63:0]      src_addr [N];
  logic [63:0]      src_qw   [N];

  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               ack_idx_q[$];
  int               ack_cyc_q[$];
  int               msi_vec_q[$];

  typedef struct {
    logic [N-1:0] req;
    int           exp_grant;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  user_int_scheduler #(
    .NUM_OF_INTERRUPTS (N),
    .MSI_VECTOR_BASE   (0),
    .MSI_VEC_WIDTH     (5),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .s_axi_clk    (clk),
    .s_axi_rstn   (rstn),
    .status_req   (status_req),
    .status_ack   (status_ack),
    .status_qword (status_qword),
    .status_addr  (status_addr),
    .int_req      (int_req),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_done      (wr_done),
    .msi_req      (msi_req),
    .msi_vector   (msi_vector),
    .msi_ack      (msi_ack),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // Responder registers and a free-running cycle counter.
  always_ff @(posedge clk) begin
    r_done_auto <= wr_valid & wr_ready;
    r_int_auto  <= status_ack;
    cyc         <= cyc + 1;
  end

  // Responders: int_req one cycle after ack, msi_ack immediately.
  always_comb begin
    wr_ready = auto_wr ? 1'b1 : man_ready;
    wr_done  = auto_wr ? r_done_auto : man_done;
    int_req  = r_int_auto;
    msi_ack  = msi_req;
  end

  // Log every ack pulse (index, cycle) and every sent MSI vector.
  always @(negedge clk) begin
    if (rstn) begin
      if ($countones(status_ack) > 1) ack_idx_q.push_back(99);
      for (int k = 0; k < N; k++) begin
        if (status_ack[k]) begin
          ack_idx_q.push_back(k);
          ack_cyc_q.push_back(cyc);
        end
      end
      if (msi_req && msi_ack) msi_vec_q.push_back(int'(msi_vector));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  // One full transaction with zero-wait responders, request dropped after grant.
  task automatic run_txn(input logic [N-1:0] req, input int exp_g, input string tag);
    int n_ack0, n_msi0, cycles, got_ack, got_msi;
    n_ack0 = ack_idx_q.size();
    n_msi0 = msi_vec_q.size();
    @(negedge clk);
    status_req = req;
    @(negedge clk);
    chk({tag, "_wr_valid"}, 64'(wr_valid), 64'd1);
    chk({tag, "_wr_addr"}, wr_addr, src_addr[exp_g]);
    chk({tag, "_wr_data"}, wr_data, src_qw[exp_g]);
    status_req = '0;
    cycles = 1;
    while (busy && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_cycles"}, 64'(cycles), 64'd6);
    got_ack = (ack_idx_q.size() == n_ack0 + 1) ? ack_idx_q[n_ack0] : -1;
    got_msi = (msi_vec_q.size() == n_msi0 + 1) ? msi_vec_q[n_msi0] : -1;
    chk({tag, "_ack_idx"}, 64'(got_ack), 64'(exp_g));
    chk({tag, "_msi_vec"}, 64'(got_msi), 64'(exp_g));
  endtask

  task automatic set_qword(input int k, input logic [63:0] v);
    status_qword[k*64 +: 64] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, m0, cnt, err_cnt;
    logic [63:0] a0, d0;

    src_addr[0] = 64'h0000_0001_0000_0A00; src_qw[0] = 64'h11;
    src_addr[1] = 64'h0000_0001_0000_0B00; src_qw[1] = 64'h22;
    src_addr[2] = 64'h0000_0001_0000_1000; src_qw[2] = 64'h5;
    src_addr[3] = 64'h0000_0001_0000_0D00; src_qw[3] = 64'h44;
    for (int k = 0; k < N; k++) begin
      status_addr[k*64 +: 64]  = src_addr[k];
      status_qword[k*64 +: 64] = src_qw[k];
    end

    // Grant sequence from reset (rr_ptr starts at 0), expected by hand.
    vecs[0]  = '{4'b0100, 2};
    vecs[1]  = '{4'b1111, 3};
    vecs[2]  = '{4'b1111, 0};
    vecs[3]  = '{4'b1111, 1};
    vecs[4]  = '{4'b1111, 2};
    vecs[5]  = '{4'b1111, 3};
    vecs[6]  = '{4'b1111, 0};
    vecs[7]  = '{4'b0001, 0};
    vecs[8]  = '{4'b1001, 3};
    vecs[9]  = '{4'b0110, 1};
    vecs[10] = '{4'b1000, 3};

    rstn       = 1'b0;
    status_req = '0;
    auto_wr    = 1'b1;
    man_ready  = 1'b0;
    man_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({status_ack, wr_valid, msi_req, busy, timeout_err, msi_vector}), 64'd0);
    chk("reset_wr_addr", wr_addr, 64'd0);
    chk("reset_wr_data", wr_data, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].req, vecs[i].exp_grant, $sformatf("vec%0d", i));
    end

    // Back-to-back with all requests held: order 0,1,2,3,0, one ack per 6 cycles.
    n0 = ack_idx_q.size();
    @(negedge clk);
    status_req = 4'b1111;
    for (int i = 0; i < 100 && ack_idx_q.size() < n0 + 5; i++) @(negedge clk);
    status_req = '0;
    wait_idle("rr");
    chk("rr_ack_count", 64'(ack_idx_q.size() - n0), 64'd5);
    if (ack_idx_q.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_order%0d", i), 64'(ack_idx_q[n0+i]), 64'(i % 4));
        if (i > 0)
          chk($sformatf("rr_spacing%0d", i), 64'(ack_cyc_q[n0+i] - ack_cyc_q[n0+i-1]), 64'd6);
      end
    end

    // Backpressure: wr_ready low for 10 cycles, then ready+done together.
    auto_wr   = 1'b0;
    man_ready = 1'b0;
    man_done  = 1'b0;
    @(negedge clk);
    status_req = 4'b0010;
    @(negedge clk);
    status_req = '0;
    chk("bp_wr_valid", 64'(wr_valid), 64'd1);
    a0 = wr_addr;
    d0 = wr_data;
    chk("bp_wr_addr", a0, src_addr[1]);
    err_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!wr_valid || wr_addr !== a0 || wr_data !== d0) err_cnt++;
    end
    chk("bp_stable", 64'(err_cnt), 64'd0);
    man_ready = 1'b1;
    man_done  = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    man_done  = 1'b0;
    chk("bp_ack_next", 64'(status_ack), 64'b0010);
    chk("bp_no_wr_wait", 64'(wr_valid), 64'd0);
    auto_wr = 1'b1;
    wait_idle("bp");

    // Source data changes and request drops right after grant.
    n0 = ack_idx_q.size();
    m0 = msi_vec_q.size();
    @(negedge clk);
    status_req = 4'b0010;
    @(negedge clk);
    set_qword(1, 64'hDEAD_BEEF_0000_0001);
    status_req = '0;
    #1;
    chk("late_wr_data", wr_data, src_qw[1]);
    wait_idle("late");
    chk("late_ack", 64'(ack_idx_q.size() > n0 ? ack_idx_q[n0] : -1), 64'd1);
    chk("late_msi", 64'(msi_vec_q.size() > m0 ? msi_vec_q[m0] : -1), 64'd1);
    repeat (12) @(negedge clk);
    chk("late_no_regrant", 64'({busy, 8'(ack_idx_q.size() - n0)}), 64'd1);
    set_qword(1, src_qw[1]);

    // Asynchronous reset while waiting for wr_done.
    auto_wr   = 1'b0;
    man_ready = 1'b1;
    @(negedge clk);
    status_req = 4'b0100;
    @(negedge clk);
    status_req = '0;
    chk("rst_wr_valid", 64'(wr_valid), 64'd1);
    @(negedge clk);
    chk("rst_in_wr_wait", 64'({busy, wr_valid}), 64'b10);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_async_ctrl", 64'({status_ack, wr_valid, msi_req, busy, timeout_err, msi_vector}), 64'd0);
    chk("rst_async_addr", wr_addr, 64'd0);
    chk("rst_async_data", wr_data, 64'd0);
    @(negedge clk);
    rstn      = 1'b1;
    man_ready = 1'b0;
    auto_wr   = 1'b1;
    n0 = ack_idx_q.size();
    m0 = msi_vec_q.size();
    repeat (10) @(negedge clk);
    chk("rst_no_ack", 64'(ack_idx_q.size() - n0), 64'd0);
    chk("rst_no_msi", 64'(msi_vec_q.size() - m0), 64'd0);
    run_txn(4'b1111, 0, "rst_ptr0");

`ifdef USER_INT_TIMEOUT_EN
    // Watchdog: wr_done withheld, 16 cycles in WR_WAIT, ack but no MSI.
    auto_wr   = 1'b0;
    man_ready = 1'b1;
    m0 = msi_vec_q.size();
    @(negedge clk);
    status_req = 4'b0011;
    @(negedge clk);
    chk("tmo_grant1", wr_addr, src_addr[1]);
    @(negedge clk);
    cnt = 0;
    while (!timeout_err && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_cycles", 64'(cnt), 64'd16);
    chk("tmo_ack", 64'(status_ack), 64'b0010);
    for (int i = 0; i < 20 && !wr_valid; i++) @(negedge clk);
    chk("tmo_next_grant", wr_addr, src_addr[0]);
    chk("tmo_no_msi", 64'(msi_vec_q.size() - m0), 64'd0);
    status_req = '0;
    auto_wr    = 1'b1;
    wait_idle("tmo");
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
`else
    chk("no_timeout_err", 64'(timeout_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/user_int_scheduler.md
Name: user_int_scheduler

Overview:
- Shares one status-write channel (posted 64-bit memory write toward the host) and one MSI request port among NUM_OF_INTERRUPTS user interrupt sources.
- Sits between the per-source user interrupt register block (status_req/status_ack/status_qword/status_addr/int_req) and the PCIe DMA write engine / MSI generator.
- Round-robin scheduler. For each granted source it writes the status qword to the host address, acks the source, waits for the source's int_req, then fires the MSI vector.

Parameters:
- NUM_OF_INTERRUPTS, 1, number of requesting sources (1..32).
- MSI_VECTOR_BASE, 0, MSI vector of source 0; source k uses MSI_VECTOR_BASE+k.
- MSI_VEC_WIDTH, 5, width of msi_vector.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with USER_INT_TIMEOUT_EN.

Ports:
- s_axi_clk  in  1  clock for all logic.
- s_axi_rstn  in  1  asynchronous active-low reset.
- status_req  in  N  per-source request for a status write; level, held until acked.
- status_ack  out  N  one-cycle pulse to the granted source after its write completes.
- status_qword  in  64*N  status data, slice k = [64k+63:64k].
- status_addr  in  64*N  host byte address, same slicing.
- int_req  in  N  per-source interrupt strobe, expected one cycle after status_ack.
- wr_valid  out  1  status write request to the DMA write engine.
- wr_ready  in  1  write engine accepts when wr_valid && wr_ready.
- wr_addr  out  64  registered address of the granted source.
- wr_data  out  64  registered qword of the granted source.
- wr_done  in  1  pulse: the accepted write is committed.
- msi_req  out  1  MSI request, held until msi_ack.
- msi_vector  out  MSI_VEC_WIDTH  vector for msi_req.
- msi_ack  in  1  MSI sent.
- busy  out  1  high whenever the FSM is not in IDLE.
- timeout_err  out  1  sticky watchdog flag; tied 0 without USER_INT_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, and all of status_ack, wr_valid, msi_req, busy, timeout_err = 0. wr_addr, wr_data and msi_vector also reset to 0.
- FSM states: IDLE, WR_REQ, WR_WAIT, ACK, WAIT_INT, MSI.
- IDLE:
  - If any status_req bit is set, pick the first set index at or after rr_ptr, cyclically.
  - Latch it into grant. Capture status_addr[grant] and status_qword[grant] into wr_addr/wr_data.
  - Go to WR_REQ. Grant-to-wr_valid latency is 1 cycle.
- WR_REQ: wr_valid=1 until the handshake.
  - On handshake: go to WR_WAIT; if wr_done is high in the same cycle, go directly to ACK.
  - wr_addr and wr_data stay stable while wr_valid is high.
- WR_WAIT: on wr_done go to ACK. wr_done outside WR_REQ/WR_WAIT is ignored.
- ACK: status_ack[grant]=1 for exactly one cycle, then go to WAIT_INT.
- WAIT_INT: on int_req[grant] go to MSI; int_req on other bits is ignored.
- MSI:
  - msi_req=1 with msi_vector=MSI_VECTOR_BASE+grant (truncated to MSI_VEC_WIDTH).
  - On msi_ack: rr_ptr = (grant+1) mod N, return to IDLE.
- Minimum idle-to-idle time is 6 cycles with zero-wait responders.
- Source data is sampled only at grant. Later changes to status_qword/status_addr, or a drop of status_req, do not affect the transaction in flight.
- A source requesting again while being served is arbitrated on a later IDLE visit.
- N=1: rr_ptr stays 0.
- All-ones status_req: grants rotate 0,1,...,N-1,0.
- Reset mid-transaction discards the grant; no ack or MSI is issued afterwards.

Optional Feature:
- Macro: USER_INT_TIMEOUT_EN.
- Defined:
  - A counter clears on each state entry and increments in WR_WAIT, WAIT_INT and MSI.
  - When it reaches TIMEOUT_CYCLES, set timeout_err (sticky until reset), drop msi_req, skip the remaining steps and return to IDLE with rr_ptr advanced.
  - An expiry in WR_WAIT still pulses status_ack so the source is not left hung.
- Undefined: no counter; the FSM waits indefinitely; timeout_err = 0.

Decomposition:
- Package user_int_pkg holds:
  - typedef enum logic [2:0] sched_state_t {IDLE, WR_REQ, WR_WAIT, ACK, WAIT_INT, MSI};
  - localparam STATUS_QWORD_W=64;
  - function rr_pick(req, ptr), returning an index plus a found flag.
- One natural sub-module, rr_arbiter: combinational N-input round-robin picker (req, rr_ptr → grant_idx, grant_found). Reusable by the DMA channel schedulers.

Test Plan:
- Single source, N=4, req[2] with addr 0x0000_0001_0000_1000, qword 0x5: expect wr_valid with those values one cycle later, then status_ack[2] pulse, int_req[2] → msi_req with vector 2, msi_ack → busy=0.
- All four requests held, zero-wait responders: grant order 0,1,2,3,0. Each transaction is 6 cycles; exactly one status_ack pulse per transaction.
- wr_ready held low 10 cycles, then wr_ready and wr_done in the same cycle: wr_addr/wr_data are stable throughout, status_ack follows on the next cycle, no WR_WAIT cycle.
- status_qword[1] changed and status_req[1] dropped after grant: the original qword is written, ack and MSI still complete, and no second grant to source 1 occurs.
- s_axi_rstn asserted during WR_WAIT: all outputs 0 immediately (asynchronous). After release, no ack/MSI for the aborted grant; rr_ptr=0.
- With USER_INT_TIMEOUT_EN and TIMEOUT_CYCLES=16: wr_done never asserted → timeout_err=1 after 16 cycles in WR_WAIT, status_ack pulses, no msi_req, the next source is granted.
